// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-word SRAM engine.
// One transaction is in flight at a time: IDLE samples requests, ISSUE pulses
// mem_start, WAIT watches mem_done with a timeout, RESPOND acks the owner.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [17:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [17:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        mem_start,
  output logic        mem_wren,
  output logic [17:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  // One spare bit so the counter can never wrap before the timeout fires.
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e            state_q, state_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_wren_q, mem_wren_d;
  logic [17:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              gnt;

  // Next-state logic: arbitration, capture, wait/timeout handling.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    mem_wren_d    = mem_wren_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    // On a tie the port that did not win last time gets the bus.
    gnt           = (req0 && req1) ? ~last_grant_q : req1;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_id_d   = gnt;
          last_grant_d = gnt;
          mem_wren_d   = gnt ? we1 : we0;
          mem_addr_d   = gnt ? addr1 : addr0;
          mem_wdata_d  = gnt ? wdata1 : wdata0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mem_done) begin
          if (!mem_wren_q) begin
            if (grant_id_q) rdata1_d = mem_rdata;
            else            rdata0_d = mem_rdata;
          end
          state_d = StRespond;
        end else if (cnt_q == CntMax) begin
          timeout_err_d = 1'b1;
          if (grant_id_q) rdata1_d = '0;
          else            rdata0_d = '0;
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      mem_wren_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      mem_wren_q    <= mem_wren_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    mem_start   = (state_q == StIssue);
    busy        = (state_q != StIdle);
    ack0        = (state_q == StRespond) && !grant_id_q;
    ack1        = (state_q == StRespond) && grant_id_q;
    grant_id    = grant_id_q;
    mem_wren    = mem_wren_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    rdata0      = rdata0_q;
    rdata1      = rdata1_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a transaction-level model predicts every
// cycle's outputs, a negedge process compares, and literal pins anchor the model.
module tb_sram_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [17:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_start, mem_wren, busy, grant_id, timeout_err;
  logic [31:0] rdata0, rdata1, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [17:0] mem_addr;

  sram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_start(mem_start), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state and per-cycle expectations.
  bit          chk_en = 0;
  bit          e_full, e_busy, e_start, e_ack0, e_ack1, e_gid, e_wren;
  logic [17:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] m_rd0, m_rd1;
  bit          m_terr, last_grant;
  int          start_cyc, ack_cyc, idle_cyc;
  bit          gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_start", 32'(mem_start), 32'(e_start));
      chk("ack0", 32'(ack0), 32'(e_ack0));
      chk("ack1", 32'(ack1), 32'(e_ack1));
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      if (e_full) begin
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        chk("mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // Event timestamps and grant order, used by the literal pins.
  always @(negedge clk) begin
    if (mem_start) begin
      start_cyc = cyc;
      gq.push_back(grant_id);
    end
    if (ack0 || ack1) ack_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_busy = 0; e_start = 0; e_ack0 = 0; e_ack1 = 0;
  endtask

  task automatic model_reset();
    last_grant = 1; m_rd0 = '0; m_rd1 = '0; m_terr = 0;
    set_idle_exp();
    e_full = 1; e_gid = 0; e_wren = 0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1; req0 = 0; req1 = 0; mem_done = 0;
    step();
    reset = 0;
    model_reset();
    chk_en = 1;
  endtask

  task automatic set_port(input bit p, input bit r, input bit we, input logic [17:0] a,
                          input logic [31:0] d);
    if (!p) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // One transaction starting in the current IDLE cycle. done_at: WAIT cycle (1-based) with
  // mem_done, 0 = never. abort_k: WAIT cycle in which reset is applied, 0 = none.
  task automatic txn(input int done_at, input logic [31:0] rd, input int abort_k,
                     input bit stray);
    bit w;
    set_idle_exp();
    idle_cyc = cyc;
    if (req0 && req1) w = ~last_grant;
    else              w = req1;
    last_grant = w;
    step();
    e_busy = 1; e_start = 1; e_full = 1; e_gid = w;
    e_wren = w ? we1 : we0; e_addr = w ? addr1 : addr0; e_wdata = w ? wdata1 : wdata0;
    mem_done = stray;
    step();
    mem_done = 0;
    e_start = 0;
    for (int k = 1; k <= TO; k++) begin
      if (k == abort_k) begin
        reset = 1; req0 = 0; req1 = 0;
        step();
        reset = 0;
        model_reset();
        return;
      end
      mem_done  = (k == done_at);
      mem_rdata = (k == done_at) ? rd : (32'hDEAD_0000 | 32'(k));
      step();
      mem_done = 0;
      if (k == done_at) begin
        if (!e_wren) begin
          if (w) m_rd1 = rd;
          else   m_rd0 = rd;
        end
        break;
      end
      if (k == TO) begin
        m_terr = 1;
        if (w) m_rd1 = '0;
        else   m_rd0 = '0;
      end
    end
    e_ack0 = !w; e_ack1 = w;
    step();
    if (w) req1 = 0;
    else   req0 = 0;
    e_full = 0;
    set_idle_exp();
  endtask

  task automatic idle_cycles(input int n, input bit pulse);
    set_idle_exp();
    for (int i = 0; i < n; i++) begin
      mem_done = pulse && (i == 0);
      step();
    end
    mem_done = 0;
  endtask

  bit exp_rr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    model_reset();
    do_reset();

    // Minimum-latency read on port 0.
    set_port(0, 1, 0, 18'h00004, 32'h0);
    txn(1, 32'h1122_3344, 0, 0);
    chk("lat_start", 32'(start_cyc - idle_cyc), 32'd1);
    chk("lat_ack", 32'(ack_cyc - idle_cyc), 32'd3);
    chk("rd0_lit", rdata0, 32'h1122_3344);
    idle_cycles(2, 0);

    // Write on port 0, done three cycles after mem_start.
    set_port(0, 1, 1, 18'h00010, 32'h80F0_2040);
    txn(3, 32'h5555_AAAA, 0, 0);
    chk("wr_ack_dist", 32'(ack_cyc - start_cyc), 32'd4);
    chk("wr_rd0_kept", rdata0, 32'h1122_3344);
    idle_cycles(1, 0);

    // Read on port 1.
    set_port(1, 1, 0, 18'h3FFFF, 32'h0);
    txn(2, 32'hCAFE_F00D, 0, 0);
    chk("rd1_lit", rdata1, 32'hCAFE_F00D);
    chk("rd0_after_rd1", rdata0, 32'h1122_3344);
    idle_cycles(1, 0);

    // Both held from reset: strict alternation starting with port 0.
    do_reset();
    gq.delete();
    set_port(0, 1, 0, 18'h00100, 32'h0);
    set_port(1, 1, 1, 18'h00200, 32'h0BAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      req0 = 1; req1 = 1;
      txn(1 + i, 32'h1000_0000 + 32'(i), 0, 0);
    end
    req0 = 0; req1 = 0;
    chk("rr_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(exp_rr[i]));
    idle_cycles(2, 0);

    // Timeout on a port 1 read with mem_done never arriving.
    set_port(1, 1, 0, 18'h00777, 32'h0);
    txn(0, 32'h0, 0, 0);
    chk("to_ack_dist", 32'(ack_cyc - start_cyc), 32'd9);
    chk("to_rd1", rdata1, 32'h0);
    chk("to_err", 32'(timeout_err), 32'd1);
    idle_cycles(2, 0);

    // Following transaction with a stray mem_done during ISSUE; the flag stays set.
    set_port(0, 1, 0, 18'h00055, 32'h0);
    txn(2, 32'h7777_0001, 0, 1);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    chk("stray_ack_dist", 32'(ack_cyc - start_cyc), 32'd3);
    idle_cycles(1, 0);

    // Reset during WAIT, then a stray mem_done in IDLE.
    set_port(0, 1, 0, 18'h00066, 32'h0);
    txn(0, 32'h0, 2, 0);
    idle_cycles(4, 1);
    chk("abort_err_clr", 32'(timeout_err), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
